// File: rtl/alu_seq.sv
`default_nettype none
// ============================================================================
//  Module   : alu_seq
//  Purpose  : Handshaked execute-stage ALU. Single-cycle ops complete the
//             cycle after accept; shifts (1 bit/cycle) and a shift-add
//             multiplier run through a small FSM. Results, flags and write
//             controls sit in a valid/ready output register.
//  Revision : 1.0 - initial release
// ============================================================================
module alu_seq #(
  parameter int WIDTH       = 16,
  parameter int IMM_WIDTH   = 8,
  parameter int SHAMT_WIDTH = 4
) (
  input  logic                 I_clk,
  input  logic                 I_reset,
  input  logic                 I_valid,
  output logic                 O_ready,
  input  logic [3:0]           I_opcode,
  input  logic                 I_opcode_mode,
  input  logic [IMM_WIDTH-1:0] I_immediate,
  input  logic [WIDTH-1:0]     I_pc,
  input  logic [WIDTH-1:0]     I_rA,
  input  logic [WIDTH-1:0]     I_rB,
  output logic                 O_valid,
  input  logic                 I_ready,
  output logic [WIDTH-1:0]     O_out,
  output logic                 O_write_rD,
  output logic                 O_write_pc,
  output logic [1:0]           O_memory_mode,
  output logic [2:0]           O_flags
);

  // Opcode map (ops.vh) plus MUL
  localparam logic [3:0] OP_ADD   = 4'h0, OP_SUB   = 4'h1, OP_OR    = 4'h2,
                         OP_XOR   = 4'h3, OP_AND   = 4'h4, OP_NOT   = 4'h5,
                         OP_READ  = 4'h6, OP_WRITE = 4'h7, OP_LOAD  = 4'h8,
                         OP_CMP   = 4'h9, OP_SHL   = 4'hA, OP_SHR   = 4'hB,
                         OP_JMP   = 4'hC, OP_JMPC  = 4'hD, OP_MUL   = 4'hE;
  localparam logic [1:0] MEM_NOP = 2'd0, MEM_READ = 2'd1, MEM_WRITE = 2'd2;
  localparam logic [WIDTH-1:0] CMP_EQ    = WIDTH'(1);
  localparam logic [WIDTH-1:0] CMP_RA_GT = WIDTH'(2);
  localparam logic [WIDTH-1:0] CMP_RB_GT = WIDTH'(4);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_SHIFT = 2'd1, S_MUL = 2'd2} state_t;

  state_t               state_q, state_d;
  logic [3:0]           op_q, op_d;
  logic                 mode_q, mode_d;
  logic [WIDTH-1:0]     a_q, a_d;
  logic [2*WIDTH-1:0]   p_q, p_d;
  logic [CW-1:0]        cnt_q, cnt_d;

  logic                 valid_q;
  logic [WIDTH-1:0]     out_q;
  logic                 wrd_q, wpc_q;
  logic [1:0]           mem_q;
  logic [2:0]           flags_q;

  logic                 accept, out_free;
  logic [SHAMT_WIDTH-1:0] shamt;
  logic [WIDTH-1:0]     imm_z, imm_s, imm_hi, jmp_tgt;

  logic [WIDTH-1:0]     sc_out;
  logic                 sc_wrd, sc_wpc, sc_c, sc_v;
  logic [1:0]           sc_mem;

  logic [WIDTH-1:0]     sh_next;
  logic                 sh_carry;
  logic [WIDTH:0]       mul_hi;
  logic [2*WIDTH-1:0]   mul_next;

  logic                 ld;
  logic [WIDTH-1:0]     ld_out;
  logic                 ld_wrd, ld_wpc, ld_c, ld_v;
  logic [1:0]           ld_mem;

  assign O_ready  = (state_q == S_IDLE) && (!valid_q || I_ready);
  assign accept   = I_valid && O_ready;
  assign out_free = !valid_q || I_ready;
  assign shamt    = I_rB[SHAMT_WIDTH-1:0];
  assign imm_z    = WIDTH'(I_immediate);
  assign imm_s    = WIDTH'($signed(I_immediate));
  assign imm_hi   = imm_z << (WIDTH - IMM_WIDTH);
  assign jmp_tgt  = I_pc + (I_opcode_mode ? imm_z : imm_s);

  // Results of everything that completes straight from the accepted inputs
  always_comb begin
    sc_out = '0;
    sc_wrd = 1'b0;
    sc_wpc = 1'b0;
    sc_mem = MEM_NOP;
    sc_c   = 1'b0;
    sc_v   = 1'b0;
    case (I_opcode)
      OP_ADD: begin
        {sc_c, sc_out} = {1'b0, I_rA} + {1'b0, I_rB};
        sc_v   = (I_rA[WIDTH-1] == I_rB[WIDTH-1]) && (sc_out[WIDTH-1] != I_rA[WIDTH-1]);
        sc_wrd = 1'b1;
      end
      OP_SUB: begin
        {sc_c, sc_out} = {1'b0, I_rA} - {1'b0, I_rB};
        sc_v   = (I_rA[WIDTH-1] != I_rB[WIDTH-1]) && (sc_out[WIDTH-1] != I_rA[WIDTH-1]);
        sc_wrd = 1'b1;
      end
      OP_OR:  begin sc_out = I_rA | I_rB; sc_wrd = 1'b1; end
      OP_XOR: begin sc_out = I_rA ^ I_rB; sc_wrd = 1'b1; end
      OP_AND: begin sc_out = I_rA & I_rB; sc_wrd = 1'b1; end
      OP_NOT: begin sc_out = ~I_rA;       sc_wrd = 1'b1; end
      OP_READ:  begin sc_out = I_rA; sc_wrd = 1'b1; sc_mem = MEM_READ;  end
      OP_WRITE: begin sc_out = I_rA; sc_mem = MEM_WRITE; end
      OP_LOAD:  begin sc_out = I_opcode_mode ? imm_z : imm_hi; sc_wrd = 1'b1; end
      OP_CMP: begin
        if (I_rA == I_rB)
          sc_out = CMP_EQ;
        else if (I_opcode_mode ? (I_rA < I_rB) : ($signed(I_rA) < $signed(I_rB)))
          sc_out = CMP_RB_GT;
        else
          sc_out = CMP_RA_GT;
        sc_wrd = 1'b1;
      end
      // Zero shift amount completes immediately with rA unchanged
      OP_SHL, OP_SHR: begin sc_out = I_rA; sc_wrd = 1'b1; end
      OP_JMP:  begin sc_out = jmp_tgt; sc_wpc = 1'b1; end
      OP_JMPC: begin sc_out = jmp_tgt; sc_wpc = (I_rA == I_rB); end
      default: ;
    endcase
  end

  // One step of the bit-serial shifter and of the shift-add multiplier
  always_comb begin
    if (op_q == OP_SHR) begin
      sh_next  = {(mode_q ? 1'b0 : a_q[WIDTH-1]), a_q[WIDTH-1:1]};
      sh_carry = a_q[0];
    end else begin
      sh_next  = {a_q[WIDTH-2:0], 1'b0};
      sh_carry = a_q[WIDTH-1];
    end
    mul_hi   = {1'b0, p_q[2*WIDTH-1:WIDTH]} + (p_q[0] ? {1'b0, a_q} : '0);
    mul_next = {mul_hi, p_q[WIDTH-1:1]};
  end

  // FSM next state, operand latching and output-register load selection
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    mode_d  = mode_q;
    a_d     = a_q;
    p_d     = p_q;
    cnt_d   = cnt_q;
    ld      = 1'b0;
    ld_out  = sc_out;
    ld_wrd  = sc_wrd;
    ld_wpc  = sc_wpc;
    ld_mem  = sc_mem;
    ld_c    = sc_c;
    ld_v    = sc_v;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          op_d   = I_opcode;
          mode_d = I_opcode_mode;
          a_d    = I_rA;
          if (((I_opcode == OP_SHL) || (I_opcode == OP_SHR)) && (shamt != '0)) begin
            cnt_d   = CW'(shamt);
            state_d = S_SHIFT;
          end else if (I_opcode == OP_MUL) begin
            p_d     = {{WIDTH{1'b0}}, I_rB};
            cnt_d   = CW'(WIDTH);
            state_d = S_MUL;
          end else begin
            ld = 1'b1;
          end
        end
      end
      S_SHIFT: begin
        if (cnt_q != CW'(1)) begin
          a_d   = sh_next;
          cnt_d = cnt_q - CW'(1);
        end else if (out_free) begin
          // Last step waits here while a previous result is still held
          a_d     = sh_next;
          cnt_d   = '0;
          state_d = S_IDLE;
          ld      = 1'b1;
          ld_out  = sh_next;
          ld_wrd  = 1'b1;
          ld_wpc  = 1'b0;
          ld_mem  = MEM_NOP;
          ld_c    = sh_carry;
          ld_v    = 1'b0;
        end
      end
      S_MUL: begin
        if (cnt_q != CW'(1)) begin
          p_d   = mul_next;
          cnt_d = cnt_q - CW'(1);
        end else if (out_free) begin
          p_d     = mul_next;
          cnt_d   = '0;
          state_d = S_IDLE;
          ld      = 1'b1;
          ld_out  = mode_q ? mul_next[WIDTH-1:0] : mul_next[2*WIDTH-1:WIDTH];
          ld_wrd  = 1'b1;
          ld_wpc  = 1'b0;
          ld_mem  = MEM_NOP;
          ld_c    = 1'b0;
          ld_v    = |mul_next[2*WIDTH-1:WIDTH];
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM state and latched operands
  always_ff @(posedge I_clk or posedge I_reset) begin
    if (I_reset) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      mode_q  <= 1'b0;
      a_q     <= '0;
      p_q     <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      mode_q  <= mode_d;
      a_q     <= a_d;
      p_q     <= p_d;
      cnt_q   <= cnt_d;
    end
  end

  // Output register: load on completion, hold until the consumer takes it
  always_ff @(posedge I_clk or posedge I_reset) begin
    if (I_reset) begin
      valid_q <= 1'b0;
      out_q   <= '0;
      wrd_q   <= 1'b0;
      wpc_q   <= 1'b0;
      mem_q   <= MEM_NOP;
      flags_q <= '0;
    end else if (ld) begin
      valid_q <= 1'b1;
      out_q   <= ld_out;
      wrd_q   <= ld_wrd;
      wpc_q   <= ld_wpc;
      mem_q   <= ld_mem;
      flags_q <= {ld_c, ld_v, (ld_out == '0)};
    end else if (I_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign O_valid       = valid_q;
  assign O_out         = out_q;
  assign O_write_rD    = wrd_q;
  assign O_write_pc    = wpc_q;
  assign O_memory_mode = mem_q;
  assign O_flags       = flags_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_seq
//  Purpose  : Directed scoreboard bench for alu_seq. Stimulus pushes the
//             expected response; a monitor pops and compares on each
//             output handshake.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_alu_seq;

  localparam logic [3:0] ADD = 4'h0, SUB = 4'h1, READ = 4'h6, WRITE = 4'h7,
                         LOAD = 4'h8, CMP = 4'h9, SHL = 4'hA, SHR = 4'hB,
                         JMP = 4'hC, JMPC = 4'hD, MUL = 4'hE, RSV = 4'hF;
  localparam logic [15:0] EQ = 16'd1, RAGT = 16'd2, RBGT = 16'd4;

  logic        I_clk = 1'b0, I_reset = 1'b1, I_valid = 1'b0, I_ready = 1'b1;
  logic [3:0]  I_opcode = '0;
  logic        I_opcode_mode = 1'b0;
  logic [7:0]  I_immediate = '0;
  logic [15:0] I_pc = '0, I_rA = '0, I_rB = '0;
  logic        O_ready, O_valid, O_write_rD, O_write_pc;
  logic [15:0] O_out;
  logic [1:0]  O_memory_mode;
  logic [2:0]  O_flags;

  alu_seq #(.WIDTH(16), .IMM_WIDTH(8), .SHAMT_WIDTH(4)) dut (
    .I_clk(I_clk), .I_reset(I_reset), .I_valid(I_valid), .O_ready(O_ready),
    .I_opcode(I_opcode), .I_opcode_mode(I_opcode_mode), .I_immediate(I_immediate),
    .I_pc(I_pc), .I_rA(I_rA), .I_rB(I_rB), .O_valid(O_valid), .I_ready(I_ready),
    .O_out(O_out), .O_write_rD(O_write_rD), .O_write_pc(O_write_pc),
    .O_memory_mode(O_memory_mode), .O_flags(O_flags)
  );

  always #5 I_clk = ~I_clk;

  typedef struct {
    logic [15:0] out;
    logic        wrd;
    logic        wpc;
    logic [1:0]  mem;
    logic [2:0]  fl;
    int          lat;
    int          acc;
  } exp_t;

  exp_t  sb[$];
  string nq[$];
  int    n_tests = 0, n_fail = 0;
  int    cyc = 0, vstart = 0, last_acc = 0;
  bit    fresh = 1'b1;

  always @(posedge I_clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: compare each result as it is handed over
  always @(negedge I_clk) begin
    if (I_reset) begin
      fresh = 1'b1;
    end else begin
      if (O_valid && fresh) begin
        vstart = cyc;
        fresh  = 1'b0;
      end
      if (O_valid && I_ready) begin
        if (sb.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected result: got out=%0h, expected no result", O_out);
        end else begin
          exp_t  e;
          string nm;
          e  = sb.pop_front();
          nm = nq.pop_front();
          chk({nm, " out"},   32'(O_out),         32'(e.out));
          chk({nm, " wrd"},   32'(O_write_rD),    32'(e.wrd));
          chk({nm, " wpc"},   32'(O_write_pc),    32'(e.wpc));
          chk({nm, " mem"},   32'(O_memory_mode), 32'(e.mem));
          chk({nm, " flags"}, 32'(O_flags),       32'(e.fl));
          if (e.lat > 0) chk({nm, " latency"}, 32'(vstart - e.acc + 1), 32'(e.lat));
        end
        fresh = 1'b1;
      end
    end
  end

  // Present one op (called at posedge+1), wait for accept, push expectation
  task automatic issue(input string nm, input logic [3:0] op, input logic md,
                       input logic [7:0] imm, input logic [15:0] pc, a, b,
                       input logic [15:0] eo, input logic ewrd, ewpc,
                       input logic [1:0] emem, input logic [2:0] efl,
                       input int elat, input bit push);
    int n;
    exp_t e;
    I_valid = 1'b1; I_opcode = op; I_opcode_mode = md; I_immediate = imm;
    I_pc = pc; I_rA = a; I_rB = b;
    n = 0;
    while (!O_ready && n < 200) begin
      @(posedge I_clk); #1; n++;
    end
    if (!O_ready) begin
      n_tests++; n_fail++;
      $display("FAIL %s accept timeout: got ready=0, expected ready=1", nm);
    end
    @(posedge I_clk); #1;
    last_acc = cyc;
    I_valid = 1'b0;
    I_rA = 16'hDEAD; I_rB = 16'hBEEF; I_pc = 16'h5A5A; I_immediate = 8'h77;
    if (push) begin
      e.out = eo; e.wrd = ewrd; e.wpc = ewpc; e.mem = emem; e.fl = efl;
      e.lat = elat; e.acc = last_acc;
      sb.push_back(e);
      nq.push_back(nm);
    end
  endtask

  task automatic drain(input string nm);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(posedge I_clk); #1; n++;
    end
    if (sb.size() != 0) begin
      n_tests++; n_fail++;
      $display("FAIL %s drain timeout: got %0d pending, expected 0", nm, sb.size());
      sb.delete(); nq.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int a1, n;
    repeat (2) @(posedge I_clk);
    #1 I_reset = 1'b0;
    #1;
    chk("reset valid", 32'(O_valid), 0);
    chk("reset ready", 32'(O_ready), 1);
    chk("reset out",   32'(O_out), 0);
    chk("reset ctl",   32'({O_write_rD, O_write_pc, O_memory_mode, O_flags}), 0);
    @(posedge I_clk); #1;

    // ADD signed overflow, ready must be up
    chk("add ready", 32'(O_ready), 1);
    issue("add ovf", ADD, 0, 0, 0, 16'h7FFF, 16'h0001, 16'h8000, 1, 0, 0, 3'b010, 1, 1);
    issue("add carry", ADD, 1, 0, 0, 16'hFFFF, 16'h0001, 16'h0000, 1, 0, 0, 3'b101, 1, 1);
    issue("sub borrow", SUB, 1, 0, 0, 16'h0000, 16'h0001, 16'hFFFF, 1, 0, 0, 3'b100, 1, 1);
    drain("alu");

    // Back-to-back: accepts on consecutive edges, one result per cycle
    issue("sub zero", SUB, 0, 0, 0, 16'd5, 16'd5, 16'h0000, 1, 0, 0, 3'b001, 1, 1);
    a1 = last_acc;
    issue("cmp signed", CMP, 0, 0, 0, 16'hFFFF, 16'h0001, RBGT, 1, 0, 0, 3'b000, 1, 1);
    chk("b2b accept gap", 32'(last_acc - a1), 1);
    issue("cmp unsigned", CMP, 1, 0, 0, 16'hFFFF, 16'h0001, RAGT, 1, 0, 0, 3'b000, 1, 1);
    issue("cmp equal", CMP, 0, 0, 0, 16'd7, 16'd7, EQ, 1, 0, 0, 3'b000, 1, 1);
    drain("b2b");

    // Shifts
    issue("shr3", SHR, 0, 0, 0, 16'h8004, 16'd3, 16'hF000, 1, 0, 0, 3'b100, 4, 1);
    drain("shr3");
    issue("shr0", SHR, 0, 0, 0, 16'h8004, 16'd0, 16'h8004, 1, 0, 0, 3'b000, 1, 1);
    issue("shl masked", SHL, 1, 0, 0, 16'h8001, 16'h0011, 16'h0002, 1, 0, 0, 3'b100, 2, 1);
    drain("shifts");

    // MUL LO with back-pressure held for 3 cycles
    issue("mul lo", MUL, 1, 0, 0, 16'd300, 16'd300, 16'h5F90, 1, 0, 0, 3'b010, 17, 1);
    I_ready = 1'b0;
    n = 0;
    while (!O_valid && n < 40) begin
      @(posedge I_clk); #1; n++;
    end
    chk("mul valid seen", 32'(O_valid), 1);
    for (int i = 0; i < 3; i++) begin
      I_valid = 1'b1; I_opcode = ADD; I_rA = 16'h1111; I_rB = 16'h2222;
      #1;
      chk("bp ready", 32'(O_ready), 0);
      chk("bp out", 32'(O_out), 32'h5F90);
      @(posedge I_clk); #1;
    end
    I_valid = 1'b0;
    I_ready = 1'b1;
    drain("mul lo");
    issue("mul hi", MUL, 0, 0, 0, 16'd300, 16'd300, 16'h0001, 1, 0, 0, 3'b010, 17, 1);
    drain("mul hi");

    // Jumps
    issue("jmpc taken", JMPC, 0, 8'hF0, 16'h0010, 16'd9, 16'd9, 16'h0000, 0, 1, 0, 3'b001, 1, 1);
    issue("jmpc not", JMPC, 0, 8'hF0, 16'h0010, 16'd9, 16'd8, 16'h0000, 0, 0, 0, 3'b001, 1, 1);
    issue("jmp wrap", JMP, 1, 8'h20, 16'hFFF0, 16'd0, 16'd0, 16'h0010, 0, 1, 0, 3'b000, 1, 1);

    // Memory, load, reserved
    issue("read", READ, 0, 0, 0, 16'h1234, 16'd0, 16'h1234, 1, 0, 2'd1, 3'b000, 1, 1);
    issue("write", WRITE, 0, 0, 0, 16'h0000, 16'h4321, 16'h0000, 0, 0, 2'd2, 3'b001, 1, 1);
    issue("load hi", LOAD, 0, 8'hAB, 0, 16'hFFFF, 16'd0, 16'hAB00, 1, 0, 0, 3'b000, 1, 1);
    issue("load lo", LOAD, 1, 8'hAB, 0, 16'hFFFF, 16'd0, 16'h00AB, 1, 0, 0, 3'b000, 1, 1);
    issue("reserved", RSV, 0, 8'hFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h0000, 0, 0, 0, 3'b001, 1, 1);
    drain("misc");

    // Reset in the 5th MUL cycle discards the operation
    issue("mul abort", MUL, 1, 0, 0, 16'd300, 16'd300, 16'h0, 0, 0, 0, 3'b0, 0, 0);
    repeat (4) @(posedge I_clk);
    #1 I_reset = 1'b1;
    @(posedge I_clk);
    #1 I_reset = 1'b0;
    #1;
    chk("abort valid", 32'(O_valid), 0);
    chk("abort ready", 32'(O_ready), 1);
    chk("abort out", 32'(O_out), 0);
    chk("abort ctl", 32'({O_write_rD, O_write_pc, O_memory_mode, O_flags}), 0);
    repeat (20) @(posedge I_clk);
    #1;
    chk("abort no result", 32'(O_valid), 0);
    issue("add after abort", ADD, 0, 0, 0, 16'd2, 16'd3, 16'd5, 1, 0, 0, 3'b000, 1, 1);
    drain("final");
    repeat (3) @(posedge I_clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, handshaked successor to the execute-stage ALU. Decodes the same 4-bit opcode set, plus MUL and variable-amount shifts.
- Width is a parameter. Multi-cycle operations run through an internal state machine.
- Results leave through a valid/ready output register, so the execute stage can stall on the writeback/memory stage.
- Also produces condition flags and a correct three-way CMP result.

Parameters:
WIDTH, 16, datapath width of I_pc/I_rA/I_rB/O_out (even, >= 8)
IMM_WIDTH, 8, immediate width (<= WIDTH)
SHAMT_WIDTH, 4, bits of I_rB used as shift amount (2**SHAMT_WIDTH <= WIDTH)

Ports:
I_clk  input  1  clock, rising edge
I_reset  input  1  asynchronous, active-high reset
I_valid  input  1  operation presented
O_ready  output  1  ALU can accept (state IDLE and output register empty or being drained)
I_opcode  input  4  ops.vh encoding; MUL = 4'hE, 4'hF reserved
I_opcode_mode  input  1  SIGNED=0/UNSIGNED=1, HI=0/LO=1 per opcode
I_immediate  input  IMM_WIDTH  immediate
I_pc  input  WIDTH  PC of the instruction
I_rA  input  WIDTH  operand A
I_rB  input  WIDTH  operand B
O_valid  output  1  result register holds a result
I_ready  input  1  consumer accepts the result
O_out  output  WIDTH  result / address / new PC
O_write_rD  output  1  write register file
O_write_pc  output  1  write PC with O_out
O_memory_mode  output  2  MEM_NOP / MEM_READ / MEM_WRITE (mem_acc.vh)
O_flags  output  3  {carry, overflow, zero} of the produced result

Behaviour:
- Reset: all outputs 0 (O_memory_mode = MEM_NOP, O_valid = 0); O_ready = 1 after reset deasserts; state IDLE.
- Reset mid-operation: the operation is aborted and the result is discarded.
- Accept: accept on a rising edge with I_valid && O_ready. Operands and opcode are latched; later input changes are ignored.
- Output register: load on completion; O_valid held with all outputs stable until I_ready.
- Throughput: O_ready = (state==IDLE) && (!O_valid || I_ready), giving 1 op/cycle for single-cycle ops.
- States: IDLE, SHIFT, MUL.
  - Single-cycle ops go IDLE->IDLE; O_valid rises the cycle after accept.
- ADD/SUB: WIDTH-bit wrap.
  - carry = unsigned carry-out (borrow for SUB).
  - overflow = signed overflow.
  - Both flags are computed regardless of mode.
- OR/AND/XOR/NOT: bitwise; carry = overflow = 0.
- LOAD:
  - HI: immediate placed in the top IMM_WIDTH bits, rest 0.
  - LO: immediate zero-extended.
- READ: O_out = rA, write_rD = 1, MEM_READ.
- WRITE: O_out = rA, write_rD = 0, MEM_WRITE.
- CMP:
  - Encodings come from cmp_res.vh.
  - rA<rB -> CMP_RB_GT; rA>rB -> CMP_RA_GT; equal -> CMP_EQ.
  - Signed or unsigned per mode; write_rD = 1.
- SHIFTL/SHIFTR:
  - n = rB[SHAMT_WIDTH-1:0].
  - n = 0: complete next cycle with O_out = rA.
  - Otherwise SHIFT for n cycles at 1 bit/cycle; O_valid n+1 cycles after accept.
  - SHIFTR mode SIGNED = arithmetic, UNSIGNED = logical.
  - carry = last bit shifted out.
- MUL:
  - Shift-add over WIDTH cycles; O_valid WIDTH+1 cycles after accept.
  - Mode LO: low WIDTH bits of the unsigned product. Mode HI: high WIDTH bits of the unsigned product.
  - overflow = high half nonzero.
- JMP: O_out = pc + immediate, wrap. SIGNED sign-extends the immediate, UNSIGNED zero-extends it. write_pc = 1, write_rD = 0.
- JMPC: same target as JMP; write_pc = (rA == rB); write_rD = 0.
- Non-register ops: JMP/JMPC/WRITE leave write_rD = 0.
- Memory mode: MEM_NOP for all opcodes except READ/WRITE.
- zero flag = (O_out == 0) for every op.
- Reserved 4'hF: completes in 1 cycle with O_out = 0 and no writes/memory access (no lock-up).
- Back-pressure during multi-cycle completion: if O_valid is still held (I_ready = 0), the FSM stays in its last cycle and does not overwrite the register until the drain.

Test Plan:
- Reset mid-MUL: assert I_reset in the 5th MUL cycle -> O_valid = 0 and O_ready = 1 after release, all outputs 0.
- ADD, SIGNED, rA=16'h7FFF, rB=1: O_ready held 1, I_ready=1 -> O_out=16'h8000, flags {c=0,v=1,z=0}, write_rD=1, one cycle latency.
- Back-to-back, I_ready=1: SUB 5-5 then CMP SIGNED rA=16'hFFFF vs rB=1 on consecutive cycles ->
  - first result: O_out=0, z=1, c=0.
  - second result: CMP_RB_GT.
  - One result per cycle, no gaps.
- SHIFTR SIGNED, rA=16'h8004, rB=3: O_valid 4 cycles after accept, O_out=16'hF000, carry=1.
  - Repeat with rB=0 -> O_out=16'h8004 after 1 cycle.
- MUL LO, rA=300, rB=300: O_valid at cycle 17, O_out=16'h5F90, overflow=1.
  - Hold I_ready=0 for 3 cycles -> outputs stable, O_ready=0, no new accept.
- JMPC SIGNED, pc=16'h0010, imm=8'hF0:
  - rA==rB -> O_out=16'h0000, write_pc=1.
  - rA!=rB -> write_pc=0.
  - JMP UNSIGNED, pc=16'hFFF0, imm=8'h20 -> O_out=16'h0010 (wrap).
